// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: ready/valid byte FIFO feeding a UART transmitter.
// Frame format is DATA_W data bits (LSB first), optional even/odd parity and
// one or two stop bits. Bit timing comes from a fractional accumulator whose
// carry out of bit ACC_W is the one-cycle baud tick.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic              CLK_50,
  input  logic              RST,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              TxD,
  output logic              BUSY,
  output logic [FIFO_AW:0]  FIFO_COUNT,
  output logic              OVERFLOW,
  output logic              BaudRate
);

  // Rounded increment: INC / 2**ACC_W approximates BAUD / CLK_FREQ.
  localparam logic [63:0] INC_WIDE =
    ((64'(BAUD) << (ACC_W - 4)) + (64'(CLK_FREQ) >> 5)) / (64'(CLK_FREQ) >> 4);
  localparam logic [ACC_W:0]   INC        = INC_WIDE[ACC_W:0];
  localparam int unsigned      DEPTH      = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] ZERO_COUNT = {(FIFO_AW + 1){1'b0}};
  localparam logic [3:0]       LAST_BIT   = 4'(DATA_W - 1);
  localparam logic             LAST_STOP  = (STOP_BITS == 32'd2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for one data word: XOR of the bits, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data);
    logic even;
    even = ^data;
    if (PARITY == 32'd2) begin
      return ~even;
    end else begin
      return even;
    end
  endfunction

  logic [ACC_W:0]     acc_r;
  logic               tick_s;

  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [FIFO_AW:0]   count_s;
  logic               ovf_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [DATA_W-1:0]  head_s;

  state_t             state_r;
  state_t             state_s;
  logic [DATA_W-1:0]  shift_r;
  logic [DATA_W-1:0]  shift_s;
  logic [3:0]         bit_cnt_r;
  logic [3:0]         bit_cnt_s;
  logic               stop_cnt_r;
  logic               stop_cnt_s;
  logic               par_r;
  logic               par_s;
  logic               txd_r;
  logic               txd_s;
  logic               busy_r;

  assign tick_s  = acc_r[ACC_W];
  assign full_s  = (count_r == FULL_COUNT);
  assign empty_s = (count_r == ZERO_COUNT);
  assign head_s  = mem_r[rd_ptr_r];
  // Ready is derived from the registered count, so it never depends on TX_VALID.
  assign push_s  = TX_VALID & TX_READY;

  assign TX_READY   = !RST && !full_s;
  assign TxD        = txd_r;
  assign BUSY       = busy_r;
  assign FIFO_COUNT = count_r;
  assign OVERFLOW   = ovf_r;
  assign BaudRate   = acc_r[ACC_W];

  // Free-running baud accumulator; the carry is cleared on the following add.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      acc_r <= {(ACC_W + 1){1'b0}};
    end else begin
      acc_r <= {1'b0, acc_r[ACC_W-1:0]} + INC;
    end
  end

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + 1'b1;
      2'b01:   count_s = count_r - 1'b1;
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow (a pop does not excuse a full push).
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      count_r  <= ZERO_COUNT;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_s;
      if (TX_VALID && full_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // FIFO storage; no reset needed since the count gates every read.
  always_ff @(posedge CLK_50) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= TX_DATA;
    end
  end

  // Frame sequencer: every move happens on a tick. A pop at the end of the
  // last stop bit starts the next start bit immediately, so queued bytes go
  // out with no idle gap.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_cnt_s  = bit_cnt_r;
    stop_cnt_s = stop_cnt_r;
    par_s      = par_r;
    txd_s      = txd_r;
    pop_s      = 1'b0;
    if (tick_s) begin
      case (state_r)
        S_IDLE: begin
          txd_s = 1'b1;
          pop_s = !empty_s;
        end
        S_START: begin
          txd_s     = shift_r[0];
          bit_cnt_s = 4'd0;
          state_s   = S_DATA;
        end
        S_DATA: begin
          if (bit_cnt_r == LAST_BIT) begin
            if (PARITY != 32'd0) begin
              txd_s   = par_r;
              state_s = S_PARITY;
            end else begin
              txd_s      = 1'b1;
              stop_cnt_s = 1'b0;
              state_s    = S_STOP;
            end
          end else begin
            shift_s   = {1'b0, shift_r[DATA_W-1:1]};
            txd_s     = shift_r[1];
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end
        S_PARITY: begin
          txd_s      = 1'b1;
          stop_cnt_s = 1'b0;
          state_s    = S_STOP;
        end
        S_STOP: begin
          if (stop_cnt_r == LAST_STOP) begin
            txd_s   = 1'b1;
            state_s = S_IDLE;
            pop_s   = !empty_s;
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end
        default: begin
          txd_s   = 1'b1;
          state_s = S_IDLE;
        end
      endcase
      if (pop_s) begin
        shift_s = head_s;
        par_s   = parity_bit(head_s);
        txd_s   = 1'b0;
        state_s = S_START;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Sequencer state plus registered line and busy outputs.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_r    <= S_IDLE;
      shift_r    <= {DATA_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 1'b0;
      par_r      <= 1'b0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
      par_r      <= par_s;
      txd_r      <= txd_s;
      busy_r     <= (state_s != S_IDLE) || (count_s != ZERO_COUNT);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo. Five instances share one
// clock and reset: a 115200 baud 8N1 line, and four fast lines (16 clocks per
// bit) in 8N1, 8E2, 8O2 and 5N1 formats.
module tb_uart_tx_fifo;

  localparam int START_BUDGET = 1200;
  localparam int TICK_BUDGET  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data    [5];
  logic [4:0] tx_data5;
  logic       tx_valid   [5];
  logic       tx_ready   [5];
  logic       txd        [5];
  logic       busy       [5];
  logic [3:0] fifo_count [5];
  logic       ovf        [5];
  logic       baud       [5];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(115200), .ACC_W(20), .DATA_W(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_AW(3)) dut_slow (
    .CLK_50(clk), .RST(rst), .TX_DATA(tx_data[0]), .TX_VALID(tx_valid[0]),
    .TX_READY(tx_ready[0]), .TxD(txd[0]), .BUSY(busy[0]), .FIFO_COUNT(fifo_count[0]),
    .OVERFLOW(ovf[0]), .BaudRate(baud[0]));

  uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(3125000), .ACC_W(20), .DATA_W(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_AW(3)) dut_fast (
    .CLK_50(clk), .RST(rst), .TX_DATA(tx_data[1]), .TX_VALID(tx_valid[1]),
    .TX_READY(tx_ready[1]), .TxD(txd[1]), .BUSY(busy[1]), .FIFO_COUNT(fifo_count[1]),
    .OVERFLOW(ovf[1]), .BaudRate(baud[1]));

  uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(3125000), .ACC_W(20), .DATA_W(8),
                 .PARITY(1), .STOP_BITS(2), .FIFO_AW(3)) dut_even (
    .CLK_50(clk), .RST(rst), .TX_DATA(tx_data[2]), .TX_VALID(tx_valid[2]),
    .TX_READY(tx_ready[2]), .TxD(txd[2]), .BUSY(busy[2]), .FIFO_COUNT(fifo_count[2]),
    .OVERFLOW(ovf[2]), .BaudRate(baud[2]));

  uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(3125000), .ACC_W(20), .DATA_W(8),
                 .PARITY(2), .STOP_BITS(2), .FIFO_AW(3)) dut_odd (
    .CLK_50(clk), .RST(rst), .TX_DATA(tx_data[3]), .TX_VALID(tx_valid[3]),
    .TX_READY(tx_ready[3]), .TxD(txd[3]), .BUSY(busy[3]), .FIFO_COUNT(fifo_count[3]),
    .OVERFLOW(ovf[3]), .BaudRate(baud[3]));

  uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(3125000), .ACC_W(20), .DATA_W(5),
                 .PARITY(0), .STOP_BITS(1), .FIFO_AW(3)) dut_five (
    .CLK_50(clk), .RST(rst), .TX_DATA(tx_data5), .TX_VALID(tx_valid[4]),
    .TX_READY(tx_ready[4]), .TxD(txd[4]), .BUSY(busy[4]), .FIFO_COUNT(fifo_count[4]),
    .OVERFLOW(ovf[4]), .BaudRate(baud[4]));

  // One-cycle push; acc reports TX_READY as seen for that edge.
  task automatic push(input int idx, input logic [7:0] b, output bit acc);
    if (idx == 4) tx_data5 = b[4:0];
    else tx_data[idx] = b;
    tx_valid[idx] = 1'b1;
    acc = tx_ready[idx];
    @(posedge clk); #1;
    tx_valid[idx] = 1'b0;
  endtask

  // Waits for a tick cycle, then returns just after the edge that consumes it.
  task automatic wait_tick(input int idx, output bit ok);
    int n = 0;
    do begin @(negedge clk); n++; end while (baud[idx] !== 1'b1 && n < TICK_BUDGET);
    ok = (baud[idx] === 1'b1);
    @(posedge clk); #1;
  endtask

  // Captures one frame: waits for the start bit, then samples TxD in the
  // last cycle of each bit (the tick cycle). gap = cycles until start seen;
  // min/max = bit lengths in clocks, start bit excluded. Lost frame -> all X.
  task automatic capture(input int idx, input int nbits, output logic [15:0] frame,
                         output int gap, output int min_len, output int max_len);
    int n = 0;
    int len;
    bit lost = 1'b0;
    frame = 16'h0000; min_len = 1000000; max_len = 0;
    do begin @(negedge clk); n++; end while (txd[idx] !== 1'b0 && n < START_BUDGET);
    gap = n;
    if (txd[idx] !== 1'b0) lost = 1'b1;
    for (int k = 0; k < nbits && !lost; k++) begin
      len = 0;
      do begin @(negedge clk); len++; end while (baud[idx] !== 1'b1 && len < TICK_BUDGET);
      if (baud[idx] !== 1'b1) begin
        lost = 1'b1;
      end else begin
        frame[k] = txd[idx];
        if (k > 0) begin
          if (len < min_len) min_len = len;
          if (len > max_len) max_len = len;
        end
      end
    end
    if (lost) frame = 16'hxxxx;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) tx_valid[i] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (tx_ready[i] !== 1'b0) begin fails++; $display("FAIL reset_ready_low[%0d]: got %b want 0", i, tx_ready[i]); end
      tests++; if (txd[i] !== 1'b1) begin fails++; $display("FAIL reset_txd[%0d]: got %b want 1", i, txd[i]); end
      tests++; if (busy[i] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
      tests++; if (fifo_count[i] !== 4'd0) begin fails++; $display("FAIL reset_count[%0d]: got %0d want 0", i, fifo_count[i]); end
      tests++; if (ovf[i] !== 1'b0) begin fails++; $display("FAIL reset_overflow[%0d]: got %b want 0", i, ovf[i]); end
    end
    rst = 1'b0;
    #1;
    tests++; if (tx_ready[1] !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b want 1", tx_ready[1]); end
  endtask

  task automatic test_single_byte();
    logic [15:0] fr; int gap, mn, mx; bit a;
    push(0, 8'h61, a);
    tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL single_busy_after_push: got %b want 1", busy[0]); end
    capture(0, 10, fr, gap, mn, mx);
    tests++; if (fr[9:0] !== 10'b1011000010) begin fails++; $display("FAIL single_frame_0x61: got %b want 1011000010", fr[9:0]); end
    tests++; if (gap < 1 || gap > 437) begin fails++; $display("FAIL single_first_latency: got %0d want 1..437", gap); end
    tests++; if (mn < 433 || mx > 435) begin fails++; $display("FAIL single_bit_len: got %0d..%0d want 433..435", mn, mx); end
    tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL single_busy_in_stop: got %b want 1", busy[0]); end
    @(negedge clk);
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL single_busy_fall: got %b want 0", busy[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [5];
    logic [15:0] fr; int gap, mn, mx; bit a, ok;
    msg[0] = 8'h75; msg[1] = 8'h4C; msg[2] = 8'h61; msg[3] = 8'h62; msg[4] = 8'h0A;
    wait_tick(1, ok);
    for (int k = 0; k < 5; k++) push(1, msg[k], a);
    tests++; if (!ok || fifo_count[1] !== 4'd5) begin fails++; $display("FAIL b2b_count_full: got %0d want 5", fifo_count[1]); end
    for (int k = 0; k < 5; k++) begin
      capture(1, 10, fr, gap, mn, mx);
      tests++; if (fr[9:0] !== {1'b1, msg[k], 1'b0}) begin fails++; $display("FAIL b2b_frame[%0d]: got %b want %b", k, fr[9:0], {1'b1, msg[k], 1'b0}); end
      tests++; if (fifo_count[1] !== 4'(4 - k)) begin fails++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, fifo_count[1], 4 - k); end
      if (k > 0) begin
        tests++; if (gap !== 1) begin fails++; $display("FAIL b2b_gap[%0d]: got %0d want 1", k, gap); end
      end
    end
    @(negedge clk);
    tests++; if (busy[1] !== 1'b0) begin fails++; $display("FAIL b2b_busy_fall: got %b want 0", busy[1]); end
  endtask

  task automatic test_overflow();
    logic [15:0] fr; int gap, mn, mx; bit a, ok;
    logic [9:0] accepted;
    wait_tick(1, ok);
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        tests++; if (fifo_count[1] !== 4'd8) begin fails++; $display("FAIL ovf_count_8: got %0d want 8", fifo_count[1]); end
        tests++; if (tx_ready[1] !== 1'b0) begin fails++; $display("FAIL ovf_ready_low: got %b want 0", tx_ready[1]); end
        tests++; if (ovf[1] !== 1'b0) begin fails++; $display("FAIL ovf_not_yet: got %b want 0", ovf[1]); end
      end
      push(1, 8'(8'hA0 + i), a);
      accepted[i] = a;
    end
    tests++; if (!ok || accepted !== 10'b0011111111) begin fails++; $display("FAIL ovf_accept_mask: got %b want 0011111111", accepted); end
    tests++; if (ovf[1] !== 1'b1) begin fails++; $display("FAIL ovf_sticky_set: got %b want 1", ovf[1]); end
    for (int k = 0; k < 8; k++) begin
      capture(1, 10, fr, gap, mn, mx);
      tests++; if (fr[9:0] !== {1'b1, 8'(8'hA0 + k), 1'b0}) begin fails++; $display("FAIL ovf_frame[%0d]: got %b want %b", k, fr[9:0], {1'b1, 8'(8'hA0 + k), 1'b0}); end
    end
    @(negedge clk);
    tests++; if (busy[1] !== 1'b0 || fifo_count[1] !== 4'd0) begin fails++; $display("FAIL ovf_drained: got busy=%b count=%0d want 0/0", busy[1], fifo_count[1]); end
    tests++; if (ovf[1] !== 1'b1) begin fails++; $display("FAIL ovf_still_sticky: got %b want 1", ovf[1]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] fr; int gap, mn, mx, n, lows; bit a, ok, all_ok;
    wait_tick(1, all_ok);
    push(1, 8'h55, a); push(1, 8'h33, a); push(1, 8'h0F, a);
    n = 0;
    do begin @(negedge clk); n++; end while (txd[1] !== 1'b0 && n < START_BUDGET);
    for (int t = 0; t < 4; t++) begin wait_tick(1, ok); all_ok &= ok; end
    tests++; if (!all_ok || txd[1] !== 1'b0 || fifo_count[1] !== 4'd2) begin fails++; $display("FAIL midrst_in_bit3: got txd=%b count=%0d want 0/2", txd[1], fifo_count[1]); end
    rst = 1'b1;
    #1;
    tests++; if (tx_ready[1] !== 1'b0) begin fails++; $display("FAIL midrst_ready_low: got %b want 0", tx_ready[1]); end
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (txd[1] !== 1'b1) begin fails++; $display("FAIL midrst_txd: got %b want 1", txd[1]); end
    tests++; if (fifo_count[1] !== 4'd0) begin fails++; $display("FAIL midrst_count: got %0d want 0", fifo_count[1]); end
    tests++; if (ovf[1] !== 1'b0) begin fails++; $display("FAIL midrst_overflow: got %b want 0", ovf[1]); end
    tests++; if (busy[1] !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy[1]); end
    lows = 0;
    repeat (48) begin @(negedge clk); if (txd[1] !== 1'b1) lows++; end
    tests++; if (lows !== 0) begin fails++; $display("FAIL midrst_line_quiet: got %0d low cycles want 0", lows); end
    push(1, 8'hC3, a);
    capture(1, 10, fr, gap, mn, mx);
    tests++; if (fr[9:0] !== {1'b1, 8'hC3, 1'b0}) begin fails++; $display("FAIL midrst_clean_frame: got %b want %b", fr[9:0], {1'b1, 8'hC3, 1'b0}); end
  endtask

  task automatic test_parity();
    logic [15:0] fr; int gap, mn, mx; bit a;
    push(2, 8'h07, a); push(2, 8'h03, a);
    capture(2, 12, fr, gap, mn, mx);
    tests++; if (fr[11:0] !== {2'b11, 1'b1, 8'h07, 1'b0}) begin fails++; $display("FAIL even_frame_07: got %b want %b", fr[11:0], {2'b11, 1'b1, 8'h07, 1'b0}); end
    tests++; if (mn !== 16 || mx !== 16) begin fails++; $display("FAIL even_bit_len: got %0d..%0d want 16..16", mn, mx); end
    capture(2, 12, fr, gap, mn, mx);
    tests++; if (fr[11:0] !== {2'b11, 1'b0, 8'h03, 1'b0}) begin fails++; $display("FAIL even_frame_03: got %b want %b", fr[11:0], {2'b11, 1'b0, 8'h03, 1'b0}); end
    tests++; if (gap !== 1) begin fails++; $display("FAIL even_gap: got %0d want 1", gap); end
    @(negedge clk);
    tests++; if (busy[2] !== 1'b0) begin fails++; $display("FAIL even_busy_fall: got %b want 0", busy[2]); end
    push(3, 8'h07, a);
    capture(3, 12, fr, gap, mn, mx);
    tests++; if (fr[11:0] !== {2'b11, 1'b0, 8'h07, 1'b0}) begin fails++; $display("FAIL odd_frame_07: got %b want %b", fr[11:0], {2'b11, 1'b0, 8'h07, 1'b0}); end
    tests++; if (busy[3] !== 1'b1) begin fails++; $display("FAIL odd_busy_in_stop: got %b want 1", busy[3]); end
    @(negedge clk);
    tests++; if (busy[3] !== 1'b0) begin fails++; $display("FAIL odd_busy_fall: got %b want 0", busy[3]); end
  endtask

  task automatic test_five_bit();
    logic [15:0] fr; int gap, mn, mx; bit a;
    push(4, 8'h1F, a); push(4, 8'h0A, a);
    capture(4, 7, fr, gap, mn, mx);
    tests++; if (fr[6:0] !== {1'b1, 5'h1F, 1'b0}) begin fails++; $display("FAIL five_frame_1f: got %b want %b", fr[6:0], {1'b1, 5'h1F, 1'b0}); end
    capture(4, 7, fr, gap, mn, mx);
    tests++; if (fr[6:0] !== {1'b1, 5'h0A, 1'b0}) begin fails++; $display("FAIL five_frame_0a: got %b want %b", fr[6:0], {1'b1, 5'h0A, 1'b0}); end
    tests++; if (gap !== 1) begin fails++; $display("FAIL five_gap: got %0d want 1", gap); end
    @(negedge clk);
    tests++; if (busy[4] !== 1'b0) begin fails++; $display("FAIL five_busy_fall: got %b want 0", busy[4]); end
  endtask

  // Scenario sequence and summary.
  initial begin
    for (int i = 0; i < 5; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = 8'h00;
    end
    tx_data5 = 5'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_parity();
    test_five_bit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
